// File: rtl/ccff_chain_loader_if.sv
// Host-side word handshakes of the configuration-chain loader:
// load words in, readback words out.
interface ccff_chain_loader_if #(
   parameter int WORD_W = 8
) ();
   logic [WORD_W-1:0] in_data;
   logic              in_valid;
   logic              in_ready;
   logic [WORD_W-1:0] rb_data;
   logic              rb_valid;
   logic              rb_ready;

   modport master (
      output in_data, in_valid, rb_ready,
      input  in_ready, rb_data, rb_valid
   );

   modport slave (
      input  in_data, in_valid, rb_ready,
      output in_ready, rb_data, rb_valid
   );
endinterface

// File: rtl/ccff_chain_loader.sv
// Serialises host words into a tile configuration chain (bit 0 first) and
// repacks the bits leaving the chain tail into readback words.
module ccff_chain_loader #(
   parameter int CHAIN_LEN = 44,
   parameter int WORD_W    = 8,
   parameter int CNT_W     = 6
) (
   input  logic               prog_clk,
   input  logic               prog_reset_n,
   input  logic               start,
   ccff_chain_loader_if.slave bus,
   output logic               ccff_head,
   input  logic               ccff_tail,
   output logic               prog_clk_en,
   output logic               busy,
   output logic               done
);
   localparam int WL_W = $clog2(WORD_W + 1);
   localparam logic [WL_W-1:0]   WL_ZERO  = {WL_W{1'b0}};
   localparam logic [WL_W-1:0]   WL_ONE   = WL_W'(1);
   localparam logic [WL_W-1:0]   WL_FULL  = WL_W'(WORD_W);
   localparam logic [CNT_W-1:0]  BIT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0]  BIT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0]  BIT_LAST = CNT_W'(CHAIN_LEN - 1);
   localparam logic [WORD_W-1:0] W_ZERO   = {WORD_W{1'b0}};

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_FLUSH = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   // A shift needs a pending bit and room for the tail bit it returns.
   function automatic logic shift_ok(input state_e st, input logic [WL_W-1:0] wl,
                                     input logic [WL_W-1:0] ac, input logic rbv);
      return (st == ST_SHIFT) && (wl != WL_ZERO) && !((ac == WL_FULL) && rbv);
   endfunction

   state_e            state_q, state_d;
   logic [WORD_W-1:0] sreg_q, sreg_d;
   logic [WL_W-1:0]   word_left_q, word_left_d;
   logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
   logic [WORD_W-1:0] asm_q, asm_d;
   logic [WL_W-1:0]   asm_cnt_q, asm_cnt_d;
   logic [WORD_W-1:0] rb_data_q, rb_data_d;
   logic              rb_valid_q, rb_valid_d;
   logic              in_ready_q, in_ready_d;
   logic              head_q, head_d;
   logic              clk_en_q, clk_en_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;

   logic              shift_s;
   logic              load_s;
   logic              handoff_s;
   logic [WORD_W-1:0] asm_base_s;
   logic [WL_W-1:0]   asm_idx_s;

   // Next-state, datapath and output decode; outputs are re-registered from
   // next-state values so the clock-gate enable comes straight off a flop.
   always_comb begin
      state_d     = state_q;
      sreg_d      = sreg_q;
      word_left_d = word_left_q;
      bit_cnt_d   = bit_cnt_q;
      asm_d       = asm_q;
      asm_cnt_d   = asm_cnt_q;
      rb_data_d   = rb_data_q;
      rb_valid_d  = rb_valid_q;
      asm_base_s  = asm_q;
      asm_idx_s   = asm_cnt_q;
      shift_s     = shift_ok(state_q, word_left_q, asm_cnt_q, rb_valid_q);
      load_s      = bus.in_valid && in_ready_q;

      case (state_q)
         ST_SHIFT: handoff_s = (asm_cnt_q == WL_FULL) && !rb_valid_q;
         ST_FLUSH: handoff_s = (asm_cnt_q != WL_ZERO) && !rb_valid_q;
         default:  handoff_s = 1'b0;
      endcase

      if (handoff_s) begin
         rb_data_d  = asm_q;
         rb_valid_d = 1'b1;
         asm_base_s = W_ZERO;
         asm_idx_s  = WL_ZERO;
      end else if (rb_valid_q && bus.rb_ready) begin
         rb_valid_d = 1'b0;
      end else begin
         rb_valid_d = rb_valid_q;
      end

      // Unfilled asm bits are always zero, so OR-in gives the zero padding.
      if (shift_s) begin
         asm_d       = asm_base_s | (WORD_W'(ccff_tail) << asm_idx_s);
         asm_cnt_d   = asm_idx_s + WL_ONE;
         sreg_d      = sreg_q >> 1'b1;
         word_left_d = word_left_q - WL_ONE;
         bit_cnt_d   = bit_cnt_q + BIT_ONE;
      end else begin
         asm_d     = asm_base_s;
         asm_cnt_d = asm_idx_s;
      end

      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               state_d     = ST_SHIFT;
               bit_cnt_d   = BIT_ZERO;
               asm_d       = W_ZERO;
               asm_cnt_d   = WL_ZERO;
               sreg_d      = W_ZERO;
               word_left_d = WL_ZERO;
            end else begin
               state_d = state_q;
            end
         end
         ST_SHIFT: begin
            if (load_s) begin
               sreg_d      = bus.in_data;
               word_left_d = WL_FULL;
            end else if (shift_s && (bit_cnt_q == BIT_LAST)) begin
               state_d     = ST_FLUSH;
               word_left_d = WL_ZERO;
               sreg_d      = W_ZERO;
            end else begin
               state_d = state_q;
            end
         end
         ST_FLUSH: begin
            if ((asm_cnt_q == WL_ZERO) && (!rb_valid_q || bus.rb_ready)) begin
               state_d = ST_DONE;
            end else begin
               state_d = state_q;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      in_ready_d = (state_d == ST_SHIFT) && (word_left_d == WL_ZERO);
      head_d     = (word_left_d != WL_ZERO) ? sreg_d[0] : 1'b0;
      clk_en_d   = shift_ok(state_d, word_left_d, asm_cnt_d, rb_valid_d);
      busy_d     = (state_d == ST_SHIFT) || (state_d == ST_FLUSH);
      done_d     = (state_d == ST_DONE);
   end

   // State and output registers; reset aborts a session and drops the gate enable.
   always_ff @(posedge prog_clk or negedge prog_reset_n) begin
      if (!prog_reset_n) begin
         state_q     <= ST_IDLE;
         sreg_q      <= W_ZERO;
         word_left_q <= WL_ZERO;
         bit_cnt_q   <= BIT_ZERO;
         asm_q       <= W_ZERO;
         asm_cnt_q   <= WL_ZERO;
         rb_data_q   <= W_ZERO;
         rb_valid_q  <= 1'b0;
         in_ready_q  <= 1'b0;
         head_q      <= 1'b0;
         clk_en_q    <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         sreg_q      <= sreg_d;
         word_left_q <= word_left_d;
         bit_cnt_q   <= bit_cnt_d;
         asm_q       <= asm_d;
         asm_cnt_q   <= asm_cnt_d;
         rb_data_q   <= rb_data_d;
         rb_valid_q  <= rb_valid_d;
         in_ready_q  <= in_ready_d;
         head_q      <= head_d;
         clk_en_q    <= clk_en_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   assign bus.in_ready = in_ready_q;
   assign bus.rb_data  = rb_data_q;
   assign bus.rb_valid = rb_valid_q;
   assign ccff_head    = head_q;
   assign prog_clk_en  = clk_en_q;
   assign busy         = busy_q;
   assign done         = done_q;
endmodule

// File: tb/tb_ccff_chain_loader.sv
// Directed sessions with random words, a behavioural chain model, and a
// bit-stream reference for the expected head sequence and readback words.
module tb_ccff_chain_loader;
   localparam int CL = 44;
   localparam int WW = 8;
   localparam int NW = 6;

   logic prog_clk = 1'b0;
   logic prog_reset_n = 1'b0;
   logic start = 1'b0;
   logic ccff_head, ccff_tail, prog_clk_en, busy, done;
   logic [CL-1:0] chain = '0;

   logic s_start = 1'b0;
   logic s_head, s_tail, s_en, s_busy, s_done;
   logic [7:0] chain8 = 8'h00;

   int vectors = 0;
   int miscompares = 0;
   bit stream[$];

   always #5 prog_clk = ~prog_clk;

   ccff_chain_loader_if #(.WORD_W(8)) bus ();
   ccff_chain_loader_if #(.WORD_W(8)) bus8 ();

   ccff_chain_loader #(.CHAIN_LEN(44), .WORD_W(8), .CNT_W(6)) dut (
      .prog_clk(prog_clk), .prog_reset_n(prog_reset_n), .start(start), .bus(bus),
      .ccff_head(ccff_head), .ccff_tail(ccff_tail), .prog_clk_en(prog_clk_en),
      .busy(busy), .done(done)
   );

   ccff_chain_loader #(.CHAIN_LEN(8), .WORD_W(8), .CNT_W(4)) dut8 (
      .prog_clk(prog_clk), .prog_reset_n(prog_reset_n), .start(s_start), .bus(bus8),
      .ccff_head(s_head), .ccff_tail(s_tail), .prog_clk_en(s_en),
      .busy(s_busy), .done(s_done)
   );

   // Chain model: the gated prog_clk shifts head in at cell 0, tail leaves the last cell.
   always @(posedge prog_clk) begin
      if (prog_clk_en === 1'b1) chain <= {chain[CL-2:0], ccff_head};
      if (s_en === 1'b1) chain8 <= {chain8[6:0], s_head};
   end
   assign ccff_tail = chain[CL-1];
   assign s_tail    = chain8[7];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic run_session(input bit use_a5, input int gap, input int mode,
                              input bit poke_start, input int abort_at);
      logic [7:0] words [NW];
      logic [7:0] exp_rb [NW];
      bit exp_head [CL];
      int base, nsh, nrb, widx, gap_left, n_keep;
      bit fire_in, fire_rb, rdy_seen, finished, poked, aborted;
      nsh = 0; nrb = 0; widx = 0; gap_left = 0;
      finished = 0; poked = 0; aborted = 0;
      for (int i = 0; i < NW; i++) words[i] = use_a5 ? 8'hA5 : 8'($urandom);
      for (int k = 0; k < CL; k++) exp_head[k] = words[k / WW][k % WW];
      for (int i = 0; i < NW; i++) exp_rb[i] = 8'h00;
      base = stream.size() - CL;
      for (int k = 0; k < CL; k++) exp_rb[k / WW][k % WW] = stream[base + k];
      n_keep = (abort_at > 0) ? abort_at : CL;
      for (int k = 0; k < n_keep; k++) stream.push_back(exp_head[k]);

      bus.rb_ready = (mode == 0) ? 1'b1 : ((mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0);
      start = 1'b1;
      bus.in_valid = 1'b1;
      bus.in_data = words[0];
      @(posedge prog_clk); #1;
      start = 1'b0;

      for (int cyc = 0; cyc < 3000; cyc++) begin
         @(negedge prog_clk);
         if (done === 1'b1) begin
            finished = 1;
            break;
         end
         fire_in = bus.in_valid && bus.in_ready;
         fire_rb = bus.rb_valid && bus.rb_ready;
         if (prog_clk_en === 1'b1) begin
            if (nsh < CL) chk("head_bit", 32'(ccff_head), 32'(exp_head[nsh]));
            else chk("extra_shift", nsh, CL);
            nsh++;
         end
         if (fire_rb) begin
            if (nrb < NW) chk("rb_data", 32'(bus.rb_data), 32'(exp_rb[nrb]));
            else chk("extra_rb", nrb, NW);
            nrb++;
         end
         if (gap > 0 && bus.in_ready && !bus.in_valid) chk("gap_clk_en", 32'(prog_clk_en), 0);
         if (mode == 2 && cyc == 60) begin
            chk("stall_shifts", nsh, 16);
            chk("stall_clk_en", 32'(prog_clk_en), 0);
         end
         rdy_seen = bus.in_ready;

         @(posedge prog_clk); #1;
         if (abort_at > 0 && nsh == abort_at) begin
            #1 prog_reset_n = 1'b0;
            #1;
            chk("abort_clk_en", 32'(prog_clk_en), 0);
            chk("abort_head", 32'(ccff_head), 0);
            chk("abort_in_ready", 32'(bus.in_ready), 0);
            chk("abort_rb_valid", 32'(bus.rb_valid), 0);
            chk("abort_rb_data", 32'(bus.rb_data), 0);
            chk("abort_busy", 32'(busy), 0);
            chk("abort_done", 32'(done), 0);
            bus.in_valid = 1'b0;
            start = 1'b0;
            @(posedge prog_clk); #1;
            prog_reset_n = 1'b1;
            aborted = 1;
            break;
         end
         start = poke_start && !poked && (nsh == 10);
         if (start) poked = 1;
         if (fire_in) begin
            widx++;
            gap_left = gap;
            bus.in_valid = (widx < NW) && (gap == 0);
            if (widx < NW) bus.in_data = words[widx];
         end else if (!bus.in_valid && widx < NW && rdy_seen && gap_left > 0) begin
            gap_left--;
            bus.in_valid = (gap_left == 0);
         end
         case (mode)
            0:       bus.rb_ready = 1'b1;
            1:       bus.rb_ready = 1'($urandom_range(0, 1));
            default: bus.rb_ready = (cyc >= 60);
         endcase
      end

      if (!aborted) begin
         chk("session_finished", 32'(finished), 1);
         chk("total_shifts", nsh, CL);
         chk("rb_words", nrb, NW);
         chk("done_level", 32'(done), 1);
         chk("busy_after", 32'(busy), 0);
         chk("clk_en_after", 32'(prog_clk_en), 0);
         @(posedge prog_clk); #1;
      end
      bus.in_valid = 1'b0;
      start = 1'b0;
   endtask

   initial begin
      logic [7:0] w, prev8;
      int n8, nacc, nrb8, acc_cyc, done_cyc;
      bit f_in, f_rb;
      bus.in_valid = 1'b0; bus.in_data = 8'h00; bus.rb_ready = 1'b0;
      bus8.in_valid = 1'b0; bus8.in_data = 8'h00; bus8.rb_ready = 1'b0;
      for (int k = 0; k < CL; k++) stream.push_back(1'b0);
      prev8 = 8'h00;

      @(negedge prog_clk);
      @(negedge prog_clk);
      chk("rst_in_ready", 32'(bus.in_ready), 0);
      chk("rst_clk_en", 32'(prog_clk_en), 0);
      chk("rst_head", 32'(ccff_head), 0);
      chk("rst_rb_valid", 32'(bus.rb_valid), 0);
      chk("rst_rb_data", 32'(bus.rb_data), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_small_en", 32'(s_en), 0);
      @(posedge prog_clk); #1;
      prog_reset_n = 1'b1;
      @(posedge prog_clk); #1;

      run_session(1'b1, 0, 0, 1'b0, 0);
      run_session(1'b1, 0, 0, 1'b0, 0);
      run_session(1'b0, 0, 2, 1'b0, 0);
      run_session(1'b0, 3, 1, 1'b0, 0);
      run_session(1'b0, 0, 1, 1'b1, 0);
      run_session(1'b0, 0, 1, 1'b0, 20);
      run_session(1'b0, 0, 0, 1'b0, 0);
      run_session(1'b0, 0, 1, 1'b0, 0);

      for (int s = 0; s < 2; s++) begin
         w = 8'($urandom);
         n8 = 0; nacc = 0; nrb8 = 0; acc_cyc = -100; done_cyc = -1;
         s_start = 1'b1;
         bus8.in_valid = 1'b1;
         bus8.in_data = w;
         bus8.rb_ready = 1'b1;
         @(posedge prog_clk); #1;
         s_start = 1'b0;
         for (int cyc = 0; cyc < 200; cyc++) begin
            @(negedge prog_clk);
            if (s_done === 1'b1) begin
               done_cyc = cyc;
               break;
            end
            f_in = bus8.in_valid && bus8.in_ready;
            f_rb = bus8.rb_valid && bus8.rb_ready;
            if (s_en === 1'b1) begin
               if (n8 < 8) chk("small_head", 32'(s_head), 32'(w[n8]));
               n8++;
            end
            if (f_in) nacc++;
            if (f_rb) begin
               chk("small_rb_data", 32'(bus8.rb_data), 32'(prev8));
               nrb8++;
               acc_cyc = cyc;
            end
            @(posedge prog_clk); #1;
            if (f_in) bus8.in_valid = 1'b0;
         end
         chk("small_shifts", n8, 8);
         chk("small_loads", nacc, 1);
         chk("small_rb_words", nrb8, 1);
         chk("small_done_latency", done_cyc - acc_cyc, 1);
         prev8 = w;
         @(posedge prog_clk); #1;
         bus8.in_valid = 1'b0;
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
